// File: rtl/seven_seg_source_arbiter_pkg.sv
// Shared types for the seven-segment source arbiter.
package seven_seg_pkg;

    localparam int SEG_NUM_W = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SHOW  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/seven_seg_source_arbiter_rr_pick.sv
// Round-robin picker: first requester after last_grant, wrapping modulo NUM_SRC.
module rr_pick #(
    parameter int NUM_SRC = 3,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    int w_idx;

    // Scan farthest-first so the nearest requester after last_grant wins.
    always_comb begin
        any    = |req;
        winner = '0;
        w_idx  = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_idx = (int'(last_grant) + k) % NUM_SRC;
            if (req[w_idx]) winner = IDX_W'(w_idx);
        end
    end

endmodule

// File: rtl/seven_seg_source_arbiter.sv
// Time-shares one seven-segment readout between NUM_SRC sources with round-robin
// grants and a minimum dwell per grant.
module seven_seg_source_arbiter
    import seven_seg_pkg::*;
#(
    parameter int NUM_SRC     = 3,
    parameter int NUM_W       = SEG_NUM_W,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [NUM_SRC*NUM_W-1:0]   src_num,
    output logic [NUM_SRC-1:0]         ack,
    output logic [NUM_W-1:0]           num,
    output logic [$clog2(NUM_SRC)-1:0] owner,
    output logic                       num_valid
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(HOLD_CYCLES);

    arb_state_t          r_state;
    logic [NUM_SRC-1:0]  r_ack;
    logic [NUM_W-1:0]    r_num;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_last;
    logic                r_valid;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_any;
    logic [IDX_W-1:0]    w_winner;
    logic [NUM_SRC-1:0]  w_owner_oh;
    logic                w_other_req;
    logic                w_expiry;
    logic [NUM_W-1:0]    w_win_val;
    logic [NUM_W-1:0]    w_own_val;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req),
        .last_grant (r_last),
        .any        (w_any),
        .winner     (w_winner)
    );

    assign w_owner_oh  = NUM_SRC'(1) << r_owner;
    assign w_other_req = |(req & ~w_owner_oh);
    assign w_expiry    = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
    assign w_win_val   = src_num[int'(w_winner)*NUM_W +: NUM_W];
    assign w_own_val   = src_num[int'(r_owner)*NUM_W +: NUM_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ack   <= '0;
            r_num   <= '0;
            r_owner <= '0;
            r_last  <= IDX_W'(NUM_SRC - 1);
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner <= w_winner;
                        r_num   <= w_win_val;
                        r_valid <= 1'b1;
                        r_ack   <= NUM_SRC'(1) << w_winner;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    r_last  <= r_owner;
                    r_cnt   <= '0;
                    r_state <= SHOW;
                end
                SHOW: begin
                    // At expiry r_last == r_owner, so the picker naturally ranks the owner last.
                    if (w_expiry) begin
                        r_cnt <= '0;
                        if (w_other_req) begin
                            r_owner <= w_winner;
                            r_num   <= w_win_val;
                            r_ack   <= NUM_SRC'(1) << w_winner;
                            r_state <= GRANT;
                        end else if (req[r_owner]) begin
                            r_num <= w_own_val;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (req[r_owner]) r_num <= w_own_val;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack       = r_ack;
    assign num       = r_num;
    assign owner     = r_owner;
    assign num_valid = r_valid;

endmodule

// File: tb/tb_seven_seg_source_arbiter.sv
// Directed bench for seven_seg_source_arbiter with an expected-value queue.
module tb_seven_seg_source_arbiter;

    localparam int NUM_SRC = 3;
    localparam int NUM_W   = 13;
    localparam int HOLD    = 4;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [NUM_SRC-1:0]       req;
    logic [NUM_SRC*NUM_W-1:0] src_num;
    logic [NUM_SRC-1:0]       ack;
    logic [NUM_W-1:0]         num;
    logic [1:0]               owner;
    logic                     num_valid;

    seven_seg_source_arbiter #(
        .NUM_SRC     (NUM_SRC),
        .NUM_W       (NUM_W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .src_num   (src_num),
        .ack       (ack),
        .num       (num),
        .owner     (owner),
        .num_valid (num_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input int v);
        src_num[i*NUM_W +: NUM_W] = NUM_W'(v);
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        q.push_back(e);
    endtask

    // Expect the full output set: ack, owner, num, num_valid.
    task automatic expect_all(input string tag, input int a, input int o, input int n, input int v);
        push({tag, ".ack"}, 32'(a));
        push({tag, ".owner"}, 32'(o));
        push({tag, ".num"}, 32'(n));
        push({tag, ".valid"}, 32'(v));
    endtask

    task automatic chk_one(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%0d", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val)
            else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk_all();
        chk_one(32'(ack));
        chk_one(32'(owner));
        chk_one(32'(num));
        chk_one(32'(num_valid));
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        src_num = '0;
        set_src(0, 10);
        set_src(2, 12);

        // Reset values, then quiet after release.
        repeat (3) tick();
        expect_all("rst_low", 0, 0, 0, 0);
        chk_all();
        reset_n = 1'b1;
        repeat (4) tick();
        expect_all("rst_idle", 0, 0, 0, 0);
        chk_all();

        // Single grant to source 1.
        set_src(1, 1234);
        req = 3'b010;
        expect_all("grant1", 3'b010, 1, 1234, 1);
        tick();
        chk_all();
        expect_all("grant1_end", 0, 1, 1234, 1);
        tick();
        chk_all();

        // Live tracking, then freeze after request drops.
        set_src(1, 100);
        push("live100", 32'd100);
        tick();
        chk_one(32'(num));
        set_src(1, 200);
        push("live200", 32'd200);
        tick();
        chk_one(32'(num));
        req = 3'b000;
        set_src(1, 300);
        push("freeze_a", 32'd200);
        tick();
        chk_one(32'(num));
        expect_all("freeze_b", 0, 1, 200, 1);
        repeat (3) tick();
        chk_all();

        // Fresh start for round-robin.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_src(1, 11);
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            expect_all($sformatf("rr%0d", i), 1 << (i % 3), i % 3, 10 + (i % 3), 1);
            tick();
            chk_all();
            if (i < 3) begin
                for (int j = 0; j < HOLD; j++) begin
                    push($sformatf("rr%0d_gap%0d", i, j), 32'd0);
                    tick();
                    chk_one(32'(ack));
                end
            end
        end

        // Dwell: source 2 asks early but waits for expiry.
        req = 3'b001;
        tick();
        req = 3'b101;
        for (int j = 0; j < HOLD - 1; j++) begin
            expect_all($sformatf("dwell%0d", j), 0, 0, 10, 1);
            tick();
            chk_all();
        end
        expect_all("dwell_sw", 3'b100, 2, 12, 1);
        tick();
        chk_all();

        // Reset during GRANT truncates ack immediately.
        reset_n = 1'b0;
        #1;
        expect_all("mid_rst", 0, 0, 0, 0);
        chk_all();
        tick();
        reset_n = 1'b1;
        expect_all("post_rst", 3'b001, 0, 10, 1);
        tick();
        chk_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_source_arbiter.md
# seven_seg_source_arbiter

Time-shares the single 4-digit seven-segment readout between several measurement sources, e.g. voltage, time/div and trigger level. It sits directly upstream of the seven-segment display top and drives its 13-bit `num` input. Requests are granted round-robin, and each grant holds the display for a minimum dwell time so a reading stays legible. While the owner keeps requesting, its value is tracked live; when it stops, the last value is frozen.

## Interface
Parameters:
- `NUM_SRC`, default 3: number of requesting sources, range 2–8.
- `NUM_W`, default 13: width of each source value and of `num`.
- `HOLD_CYCLES`, default 50_000_000: minimum dwell per grant, in `clk` cycles (1 s at 50 MHz); must be ≥ 2.

Ports:
- `clk`  in  1: single system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  NUM_SRC: per-source display request, level-sensitive.
- `src_num`  in  NUM_SRC*NUM_W: packed source values; source i occupies bits [i*NUM_W +: NUM_W].
- `ack`  out  NUM_SRC: one-cycle grant pulse to the newly granted source.
- `num`  out  NUM_W: registered value to the display top.
- `owner`  out  $clog2(NUM_SRC): index of the current owner.
- `num_valid`  out  1: high once any source has been granted.

## Operation
- States are IDLE, GRANT and SHOW.
- Reset values: state = IDLE, `num` = 0, `owner` = 0, `num_valid` = 0, `ack` = 0, hold counter = 0, `last_grant` = NUM_SRC-1, so source 0 wins first.
- **IDLE.** If any `req` bit is high, pick the winner `g` (see pick rule), then:
  - `owner` <= g;
  - `num` <= src_num[g];
  - `num_valid` <= 1;
  - state -> GRANT.
  - Otherwise stay in IDLE.
- **GRANT.** Lasts exactly 1 cycle.
  - `ack[owner]` = 1; all other `ack` bits are 0.
  - `last_grant` <= owner; counter <= 0; state -> SHOW.
- **SHOW.** The counter increments every cycle.
  - If `req[owner]` = 1, `num` <= src_num[owner] every cycle (live tracking).
  - If `req[owner]` = 0, `num` holds its value (frozen).
- **Hold expiry** occurs on the edge where counter == HOLD_CYCLES-1:
  - If any source other than the owner requests, pick the winner, load `owner`/`num`, and go to GRANT.
  - Else if `req[owner]` = 1, counter <= 0 and stay in SHOW (same owner, no new `ack`).
  - Else counter <= 0 and stay in SHOW with the frozen value. The next request from any source is evaluated at the next expiry.
- **Pick rule:** search indices `last_grant`+1, +2, … modulo NUM_SRC and take the first one with `req` high. The current owner is therefore considered last.
- Requests that drop before expiry are lost; no request latching.
- `num` is passed through unmodified. Sign and digit decode belong downstream.
- `num_valid` never returns to 0 except on reset.

## Timing
- IDLE grant latency: `req` high before edge k → `num`/`owner` valid after edge k; `ack` high for cycle k..k+1; SHOW from edge k+1.
- Dwell: the new owner's first SHOW cycle through expiry spans HOLD_CYCLES cycles, plus 1 GRANT cycle. Minimum switch period is therefore HOLD_CYCLES+1.
- Live tracking in SHOW adds one-cycle latency from `src_num` to `num`.
- Simultaneous events:
  - An owner request drop coinciding with expiry follows the "other requests" rule using sampled values.
  - All `req` bits high give strict rotation 0, 1, 2, 0, …
- Reset mid-operation: all outputs return to reset values immediately. The `ack` pulse is truncated and no residual grant remains.
- `src_num` is assumed synchronous to `clk`. The block adds no synchronisers.

## Structure
- `seven_seg_pkg`: `NUM_W` default constant; `arb_state_t` enum {IDLE, GRANT, SHOW}.
- Sub-module `rr_pick` (combinational): inputs `req` and `last_grant`; outputs `any` and `winner`. It is reused for both the IDLE and expiry decisions.
- One counter sized $clog2(HOLD_CYCLES).

## Test plan
All scenarios use NUM_SRC=3 and HOLD_CYCLES=4.
- Reset values: hold `reset_n` low, then release with `req` = 000 → `num` = 0, `num_valid` = 0, `ack` = 000, `owner` = 0 indefinitely.
- Single grant: `req` = 010, src1 = 13'd1234 → after 1 edge `num` = 1234 and `owner` = 1; `ack` = 010 for exactly 1 cycle; `num_valid` = 1.
- Live/freeze: src1 steps 100 → 200 while requesting → `num` = 200 one cycle later. Drop `req[1]`, then change src1 to 300 → `num` stays 200.
- Round-robin: `req` = 111 held, all values distinct → owner sequence 0, 1, 2, 0; each `ack` 1 cycle; 5 cycles (1 GRANT + 4 SHOW) between `ack` pulses.
- Dwell: owner 0 in SHOW, `req[2]` rises at SHOW cycle 1 → switch occurs only at expiry; `ack[2]` appears in the cycle after the 4th SHOW cycle.
- Mid-operation reset: assert `reset_n` low during the GRANT cycle → `ack` drops immediately and `num` = 0. After release, src0 wins first if requesting.
